// File: rtl/lfsr_multi.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_multi
// Description : Fibonacci/Galois LFSR emitting OUT_W bits per enabled clock,
//               with seed load, lockup recovery and sequence-wrap pulse.
// Revision    : 1.0
// ============================================================================
module lfsr_multi #(
  parameter int              WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS = 5'h12,
  parameter logic [WIDTH-1:0] SEED = 5'h09,
  parameter int              OUT_W = 1,
  parameter int              MODE  = 0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic [WIDTH-1:0] state,
  output logic             lockup,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_zero = '0;

  if (SEED == c_zero) begin : g_bad_seed
    $error("lfsr_multi: SEED must be nonzero");
  end
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_multi: WIDTH out of range 2..32");
  end
  if (OUT_W < 1 || OUT_W > 32) begin : g_bad_outw
    $error("lfsr_multi: OUT_W out of range 1..32");
  end

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_seed;
  logic [OUT_W-1:0] r_out;
  logic             r_out_valid;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next;
  logic [OUT_W-1:0] w_bits;
  logic             w_lockup;

  // All OUT_W steps unroll into one combinational chain; out[k] is step k.
  if (MODE == 0) begin : g_fib
    always_comb begin
      logic [WIDTH-1:0] v;
      v      = r_state;
      w_bits = '0;
      for (int k = 0; k < OUT_W; k++) begin
        w_bits[k] = v[WIDTH-1];
        v         = {v[WIDTH-2:0], ^(v & TAPS)};
      end
      w_next = v;
    end
  end else begin : g_gal
    always_comb begin
      logic [WIDTH-1:0] v;
      v      = r_state;
      w_bits = '0;
      for (int k = 0; k < OUT_W; k++) begin
        w_bits[k] = v[0];
        v         = (v >> 1) ^ (v[0] ? TAPS : c_zero);
      end
      w_next = v;
    end
  end

  assign w_lockup = (r_state == c_zero);

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_state     <= SEED;
      r_seed      <= SEED;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_wrap      <= 1'b0;
    end else if (load) begin
      r_state     <= seed_in;
      r_seed      <= seed_in;
      r_out_valid <= 1'b0;
      r_wrap      <= 1'b0;
    end else if (en && w_lockup) begin
      // Recover to the elaboration seed; a zero runtime seed would relock.
      r_state     <= SEED;
      r_out_valid <= 1'b0;
      r_wrap      <= 1'b0;
    end else if (en) begin
      r_state     <= w_next;
      r_out       <= w_bits;
      r_out_valid <= 1'b1;
      r_wrap      <= (w_next == r_seed);
    end else begin
      r_out_valid <= 1'b0;
      r_wrap      <= 1'b0;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign state     = r_state;
  assign lockup    = w_lockup;
  assign wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_multi
// Description : Self-checking bench: three lfsr_multi configurations against
//               an integer-arithmetic reference plus directed literal checks.
// Revision    : 1.0
// ============================================================================
module tb_lfsr_multi;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic       en [3];
  logic       load [3];
  logic [4:0] seed_in [3];
  logic       chk_on = 1'b0;

  logic [0:0] out_a, out_c;
  logic [3:0] out_b;
  logic [4:0] state_a, state_b, state_c;
  logic [2:0] dval, dlock, dwrap;
  logic [3:0] dout [3];
  logic [4:0] dstate [3];

  int npass = 0;
  int ntotal = 0;

  // Index 0: Fibonacci x1, 1: Fibonacci x4, 2: Galois x1
  int ctaps [3] = '{'h12, 'h12, 'h14};
  int cseed [3] = '{'h09, 'h09, 'h01};
  int cmode [3] = '{0, 0, 1};
  int cow   [3] = '{1, 4, 1};

  int mst [3], mseedr [3], mout [3], mval [3], mwrap [3];

  always #5 clk = ~clk;

  lfsr_multi #(.WIDTH(5), .TAPS(5'h12), .SEED(5'h09), .OUT_W(1), .MODE(0)) u_a (
    .clk(clk), .rst_(rst_), .en(en[0]), .load(load[0]), .seed_in(seed_in[0]),
    .out(out_a), .out_valid(dval[0]), .state(state_a), .lockup(dlock[0]), .wrap(dwrap[0]));
  lfsr_multi #(.WIDTH(5), .TAPS(5'h12), .SEED(5'h09), .OUT_W(4), .MODE(0)) u_b (
    .clk(clk), .rst_(rst_), .en(en[1]), .load(load[1]), .seed_in(seed_in[1]),
    .out(out_b), .out_valid(dval[1]), .state(state_b), .lockup(dlock[1]), .wrap(dwrap[1]));
  lfsr_multi #(.WIDTH(5), .TAPS(5'h14), .SEED(5'h01), .OUT_W(1), .MODE(1)) u_c (
    .clk(clk), .rst_(rst_), .en(en[2]), .load(load[2]), .seed_in(seed_in[2]),
    .out(out_c), .out_valid(dval[2]), .state(state_c), .lockup(dlock[2]), .wrap(dwrap[2]));

  assign dout[0] = {3'b000, out_a};
  assign dout[1] = out_b;
  assign dout[2] = {3'b000, out_c};
  assign dstate[0] = state_a;
  assign dstate[1] = state_b;
  assign dstate[2] = state_c;

  task automatic chk(input string name, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
  endtask

  // One single-bit LFSR step on a 5-bit integer state.
  function automatic int step1(input int s, input int taps, input int mode);
    if (mode == 0) return ((s * 2) + ($countones(s & taps) % 2)) % 32;
    return (s / 2) ^ ((s % 2 == 1) ? taps : 0);
  endfunction

  function automatic int emitted(input int s, input int mode);
    return (mode == 0) ? (s / 16) % 2 : s % 2;
  endfunction

  function automatic int run_state(input int s, input int taps, input int mode, input int n);
    int v = s;
    for (int k = 0; k < n; k++) v = step1(v, taps, mode);
    return v;
  endfunction

  function automatic int run_bits(input int s, input int taps, input int mode, input int n);
    int v = s;
    int b = 0;
    for (int k = 0; k < n; k++) begin
      b = b + (emitted(v, mode) << k);
      v = step1(v, taps, mode);
    end
    return b;
  endfunction

  always @(posedge clk or posedge rst_) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_) begin
        mst[i] <= cseed[i]; mseedr[i] <= cseed[i]; mout[i] <= 0; mval[i] <= 0; mwrap[i] <= 0;
      end else if (load[i]) begin
        mst[i] <= int'(seed_in[i]); mseedr[i] <= int'(seed_in[i]); mval[i] <= 0; mwrap[i] <= 0;
      end else if (en[i] && mst[i] == 0) begin
        mst[i] <= cseed[i]; mval[i] <= 0; mwrap[i] <= 0;
      end else if (en[i]) begin
        mst[i]   <= run_state(mst[i], ctaps[i], cmode[i], cow[i]);
        mout[i]  <= run_bits(mst[i], ctaps[i], cmode[i], cow[i]);
        mval[i]  <= 1;
        mwrap[i] <= (run_state(mst[i], ctaps[i], cmode[i], cow[i]) == mseedr[i]) ? 1 : 0;
      end else begin
        mval[i] <= 0; mwrap[i] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_out[%0d]", i), int'(dout[i]), mout[i]);
        chk($sformatf("model_state[%0d]", i), int'(dstate[i]), mst[i]);
        chk($sformatf("model_valid[%0d]", i), int'(dval[i]), mval[i]);
        chk($sformatf("model_lockup[%0d]", i), int'(dlock[i]), (mst[i] == 0) ? 1 : 0);
        chk($sformatf("model_wrap[%0d]", i), int'(dwrap[i]), mwrap[i]);
      end
    end
  end

  task automatic edge_wait();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int fib_out [5] = '{0, 1, 0, 0, 1};
    int fib_st  [5] = '{'h12, 'h04, 'h08, 'h10, 'h01};
    int wraps = 0;
    int first_wrap = 0;
    int second_wrap = 0;
    int first_st = 0;

    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; load[i] = 1'b0; seed_in[i] = 5'd0;
    end
    #12;
    chk("rst_state", int'(state_a), 'h09);
    chk("rst_out", int'(out_a), 0);
    chk("rst_valid", int'(dval[0]), 0);
    chk("rst_lockup", int'(dlock[0]), 0);
    chk("rst_wrap", int'(dwrap[0]), 0);
    @(posedge clk); #1;
    rst_ = 1'b0;
    chk_on = 1'b1;
    #1;

    // Fibonacci sequence and wrap period on config A
    en[0] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      edge_wait();
      chk($sformatf("fib_out_%0d", e), int'(out_a), fib_out[e-1]);
      chk($sformatf("fib_state_%0d", e), int'(state_a), fib_st[e-1]);
      chk($sformatf("fib_valid_%0d", e), int'(dval[0]), 1);
    end
    for (int e = 6; e <= 65; e++) begin
      edge_wait();
      if (dwrap[0]) begin
        wraps++;
        if (wraps == 1) begin first_wrap = e; first_st = int'(state_a); end
        if (wraps == 2) second_wrap = e;
      end
    end
    en[0] = 1'b0;
    chk("wrap_first_edge", first_wrap, 31);
    chk("wrap_first_state", first_st, 'h09);
    chk("wrap_second_edge", second_wrap, 62);
    chk("wrap_count", wraps, 2);

    // Four bits per clock on config B
    en[1] = 1'b1;
    edge_wait();
    chk("par_out_1", int'(out_b), 'b0010);
    chk("par_state_1", int'(state_b), 'h10);
    edge_wait();
    chk("par_out_2", int'(out_b), 'b0001);
    chk("par_state_2", int'(state_b), 'h0A);
    en[1] = 1'b0;

    // Zero seed, lockup hold, recovery, load-over-en priority on config A
    load[0] = 1'b1; seed_in[0] = 5'h00;
    edge_wait();
    load[0] = 1'b0;
    chk("load0_state", int'(state_a), 0);
    chk("load0_lockup", int'(dlock[0]), 1);
    for (int e = 0; e < 3; e++) begin
      edge_wait();
      chk($sformatf("lock_hold_%0d", e), int'(dlock[0]), 1);
    end
    en[0] = 1'b1;
    edge_wait();
    chk("recover_state", int'(state_a), 'h09);
    chk("recover_valid", int'(dval[0]), 0);
    chk("recover_lockup", int'(dlock[0]), 0);
    load[0] = 1'b1; seed_in[0] = 5'h15;
    edge_wait();
    load[0] = 1'b0;
    chk("ld_pri_state", int'(state_a), 'h15);
    chk("ld_pri_valid", int'(dval[0]), 0);
    for (int e = 1; e <= 31; e++) begin
      edge_wait();
      if (e == 30) chk("rtseed_nowrap_30", int'(dwrap[0]), 0);
      if (e == 31) begin
        chk("rtseed_wrap_31", int'(dwrap[0]), 1);
        chk("rtseed_state_31", int'(state_a), 'h15);
      end
    end
    en[0] = 1'b0;

    // Galois step then asynchronous reset between edges
    en[2] = 1'b1;
    edge_wait();
    en[2] = 1'b0;
    chk("gal_out", int'(out_c), 1);
    chk("gal_state", int'(state_c), 'h14);
    #1;
    rst_ = 1'b1;
    #1;
    chk("async_state_c", int'(state_c), 'h01);
    chk("async_out_c", int'(out_c), 0);
    chk("async_state_a", int'(state_a), 'h09);
    chk("async_valid_c", int'(dval[2]), 0);
    edge_wait();
    rst_ = 1'b0;

    // Runtime seed must be forgotten after reset: wrap now returns at 0x09
    en[0] = 1'b1;
    for (int e = 1; e <= 31; e++) edge_wait();
    chk("post_rst_wrap", int'(dwrap[0]), 1);
    chk("post_rst_state", int'(state_a), 'h09);
    en[0] = 1'b0;
    edge_wait();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
`default_nettype wire
